// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the VGA write port for map/Link/enemy drawers; a grant lasts one whole burst.
// Pixels reach vga_* one cycle after accept; req_ready follows grant, and the VGA side never stalls.
module draw_port_arbiter #(
   parameter int             X_W         = 8,
   parameter int             Y_W         = 7,
   parameter int             C_W         = 3,
   parameter logic [C_W-1:0] TRANSPARENT = 3'b101
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       req_valid,
   input  logic [3*X_W-1:0] req_x,
   input  logic [3*Y_W-1:0] req_y,
   input  logic [3*C_W-1:0] req_colour,
   input  logic [2:0]       req_last,
   output logic [2:0]       req_ready,
   output logic [2:0]       grant,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [C_W-1:0]   vga_colour,
   output logic             vga_plot,
   output logic [2:0]       done_pulse,
   input  logic             frame_start,
   output logic [15:0]      plot_count
);

   typedef enum logic {ARB, BURST} state_t;

   state_t         state;
   logic [1:0]     rr_ptr;
   logic [1:0]     ord [3];
   logic [1:0]     pick;
   logic           pick_vld;
   logic           acc;
   logic           sel_vis;
   logic           sel_last;
   logic [X_W-1:0] sel_x;
   logic [Y_W-1:0] sel_y;
   logic [C_W-1:0] sel_c;
   logic [1:0]     next_ptr;

   assign req_ready = grant;
   assign acc       = |(req_valid & grant);
   assign sel_vis   = (sel_c != TRANSPARENT);

   // Search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); the earliest valid entry wins.
   always_comb begin
      ord[0]   = rr_ptr;
      ord[1]   = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
      ord[2]   = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
      pick_vld = |req_valid;
      pick     = ord[0];
      if (req_valid[ord[2]]) pick = ord[2];
      if (req_valid[ord[1]]) pick = ord[1];
      if (req_valid[ord[0]]) pick = ord[0];
   end

   always_comb begin
      sel_x    = '0;
      sel_y    = '0;
      sel_c    = '0;
      sel_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (grant[i]) begin
            sel_x    = req_x[i*X_W +: X_W];
            sel_y    = req_y[i*Y_W +: Y_W];
            sel_c    = req_colour[i*C_W +: C_W];
            sel_last = req_last[i];
         end
      end
      next_ptr = grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ARB;
         rr_ptr     <= 2'd0;
         grant      <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         done_pulse <= '0;
         plot_count <= '0;
      end else begin
         vga_plot   <= 1'b0;
         done_pulse <= '0;

         if (frame_start)
            plot_count <= (acc && sel_vis) ? 16'd1 : 16'd0;
         else if (acc && sel_vis && plot_count != 16'hFFFF)
            plot_count <= plot_count + 16'd1;

         case (state)
            ARB: begin
               if (pick_vld) begin
                  grant <= 3'b001 << pick;
                  state <= BURST;
               end
            end
            BURST: begin
               if (acc) begin
                  vga_x      <= sel_x;
                  vga_y      <= sel_y;
                  vga_colour <= sel_c;
                  vga_plot   <= sel_vis;
                  if (sel_last) begin
                     done_pulse <= grant;
                     grant      <= '0;
                     rr_ptr     <= next_ptr;
                     state      <= ARB;
                  end
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule
